// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequence controller for the OSECPU core.
// Fetches an opcode word plus EXT_WORDS extension words for long opcodes,
// hands the instruction to the executor with a valid/done handshake and
// owns the pc, the control register (HLT, SKIP) and a retired counter.
module fetch_sequencer #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int EXT_WORDS = 1,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int CNT_W     = 32,
   parameter logic [7:0] OP_LBSET  = 8'h01,
   parameter logic [7:0] OP_LIMM32 = 8'h02,
   parameter logic [7:0] OP_CND    = 8'h04,
   parameter logic [7:0] OP_HLT    = 8'hFF
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic                          mem_req,
   input  logic                          mem_ack,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic [DATA_W-1:0]             instr0,
   output logic [EXT_WORDS*DATA_W-1:0]   instr_ext,
   output logic                          exec_valid,
   input  logic                          exec_done,
   input  logic                          cond_lsb,
   input  logic                          pc_update_req,
   input  logic [ADDR_W-1:0]             pc_update_addr,
   input  logic                          resume,
   output logic [ADDR_W-1:0]             pc,
   output logic [7:0]                    cr,
   output logic [1:0]                    state,
   output logic [CNT_W-1:0]              retired
);

   // state  | meaning
   // FETCH0 | requesting the opcode word at pc
   // FETCHX | requesting extension word ext_cnt of a long opcode
   // EXEC   | instruction presented to the executor, waiting for exec_done
   // HALT   | HLT executed; frozen until resume
   typedef enum logic [1:0] {
      FETCH0 = 2'd0,
      FETCHX = 2'd1,
      EXEC   = 2'd2,
      HALT   = 2'd3
   } state_t;

   state_t                            state_q;
   logic [ADDR_W-1:0]                 pc_q;
   logic [ADDR_W-1:0]                 pc_inc_d;
   logic [DATA_W-1:0]                 instr0_q;
   logic [EXT_WORDS-1:0][DATA_W-1:0]  ext_q;
   logic [1:0]                        ext_cnt_q;
   logic                              skip_q;
   logic                              hlt_q;
   logic [CNT_W-1:0]                  retired_q;

   logic [7:0] fetch_op;
   logic [7:0] exec_op;
   logic       fetch_long;
   logic       ext_last;

   assign fetch_op   = mem_rdata[DATA_W-1 -: 8];
   assign exec_op    = instr0_q[DATA_W-1 -: 8];
   assign fetch_long = (fetch_op == OP_LIMM32) || (fetch_op == OP_LBSET);
   assign ext_last   = (ext_cnt_q == 2'(EXT_WORDS-1));
   assign pc_inc_d   = pc_q + ADDR_W'(1);

   // Request is gated by reset so it drops the instant reset asserts,
   // even though the state register only reads FETCH0 at that point.
   assign mem_req    = reset && ((state_q == FETCH0) || (state_q == FETCHX));
   assign mem_addr   = mem_req ? pc_q : '0;
   assign exec_valid = (state_q == EXEC);

   assign instr0    = instr0_q;
   assign instr_ext = ext_q;
   assign pc        = pc_q;
   assign cr        = {6'b0, skip_q, hlt_q};
   assign state     = state_q;
   assign retired   = retired_q;

   // Sequencer FSM together with the pc, instruction and control registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH0;
         pc_q      <= RESET_PC;
         instr0_q  <= '0;
         ext_q     <= '0;
         ext_cnt_q <= '0;
         skip_q    <= 1'b0;
         hlt_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         case (state_q)
            FETCH0: begin
               if (mem_ack) begin
                  instr0_q  <= mem_rdata;
                  pc_q      <= pc_inc_d;
                  ext_cnt_q <= '0;
                  if (fetch_long) begin
                     state_q <= FETCHX;
                  end else if (skip_q) begin
                     skip_q  <= 1'b0;
                     state_q <= FETCH0;
                  end else begin
                     state_q <= EXEC;
                  end
               end
            end
            FETCHX: begin
               if (mem_ack) begin
                  for (int k = 0; k < EXT_WORDS; k++) begin
                     if (ext_cnt_q == 2'(k)) ext_q[k] <= mem_rdata;
                  end
                  pc_q      <= pc_inc_d;
                  ext_cnt_q <= ext_cnt_q + 2'd1;
                  if (ext_last) begin
                     if (skip_q) begin
                        skip_q  <= 1'b0;
                        state_q <= FETCH0;
                     end else begin
                        state_q <= EXEC;
                     end
                  end
               end
            end
            EXEC: begin
               if (exec_done) begin
                  if (exec_op == OP_HLT) begin
                     hlt_q   <= 1'b1;
                     state_q <= HALT;
                  end else begin
                     if (pc_update_req) pc_q <= pc_update_addr;
                     skip_q    <= (exec_op == OP_CND) && !cond_lsb;
                     retired_q <= retired_q + CNT_W'(1);
                     state_q   <= FETCH0;
                  end
               end
            end
            HALT: begin
               if (resume) begin
                  hlt_q   <= 1'b0;
                  state_q <= FETCH0;
               end
            end
            default: state_q <= FETCH0;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a word-addressed memory model, an
// executor with programmable done delay, and a scoreboard of expected
// executed instructions (pc after fetch, opcode word, extension words).
module tb_fetch_sequencer;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_LBSET  = 8'h01;
   localparam logic [7:0] OP_LIMM32 = 8'h02;
   localparam logic [7:0] OP_CND    = 8'h04;
   localparam logic [7:0] OP_HLT    = 8'hFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] instr0;
   logic [63:0] instr_ext;
   logic        exec_valid;
   logic        exec_done = 1'b0;
   logic        cond_lsb = 1'b1;
   logic        pc_update_req = 1'b0;
   logic [15:0] pc_update_addr = 16'h0;
   logic        resume = 1'b0;
   logic [15:0] pc;
   logic [7:0]  cr;
   logic [1:0]  state;
   logic [31:0] retired;

   logic        ack_en = 1'b1;
   logic        force_ack = 1'b0;
   int          done_delay = 0;
   logic [31:0] mem [0:65535];

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] pc;
      logic [31:0] i0;
      logic [63:0] ext;
      bit          chk_ext;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   assign mem_ack   = (mem_req | force_ack) & ack_en;
   assign mem_rdata = mem[mem_addr];

   fetch_sequencer #(
      .ADDR_W(16), .DATA_W(32), .EXT_WORDS(2), .RESET_PC(16'h0), .CNT_W(32),
      .OP_LBSET(OP_LBSET), .OP_LIMM32(OP_LIMM32), .OP_CND(OP_CND), .OP_HLT(OP_HLT)
   ) dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_req(mem_req),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr0(instr0),
      .instr_ext(instr_ext), .exec_valid(exec_valid), .exec_done(exec_done),
      .cond_lsb(cond_lsb), .pc_update_req(pc_update_req),
      .pc_update_addr(pc_update_addr), .resume(resume), .pc(pc), .cr(cr),
      .state(state), .retired(retired)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] p, input logic [31:0] i0,
                       input logic [63:0] ext, input bit chk);
      exp_t e;
      e.pc = p; e.i0 = i0; e.ext = ext; e.chk_ext = chk;
      sb.push_back(e);
   endtask

   task automatic wait_for(input logic [1:0] st, input logic [15:0] p, input string tag);
      int n = 0;
      while (!(state == st && pc == p) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, {46'h0, state, pc}, {46'h0, st, p});
   endtask

   task automatic wait_halt();
      int n = 0;
      while (state != 2'd3 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("halt_reached", 64'(state), 64'd3);
   endtask

   task automatic pulse_resume();
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
   endtask

   // Executor model and scoreboard consumer: compares on the first EXEC cycle.
   initial begin
      int exec_cyc = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (exec_valid) begin
            if (exec_cyc == 0) begin
               if (sb.size() == 0) begin
                  check("sb_unexpected_exec", 64'(pc), 64'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  check("exec_pc", 64'(pc), 64'(e.pc));
                  check("exec_instr0", 64'(instr0), 64'(e.i0));
                  if (e.chk_ext) check("exec_instr_ext", instr_ext, e.ext);
               end
            end
            exec_done = (exec_cyc >= done_delay);
            exec_cyc++;
         end else begin
            exec_done = 1'b0;
            exec_cyc  = 0;
         end
      end
   end

   initial begin
      int n;
      for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
      mem[0]  = {OP_NOP, 24'h000001};
      mem[1]  = {OP_NOP, 24'h000002};
      mem[2]  = {OP_HLT, 24'h000003};
      mem[3]  = {OP_NOP, 24'h000033};
      mem[4]  = {OP_LIMM32, 24'h000044};
      mem[5]  = 32'hAAAA_0001;
      mem[6]  = 32'hBBBB_0002;
      mem[7]  = {OP_CND, 24'h000077};
      mem[8]  = {OP_LBSET, 24'h000088};
      mem[9]  = 32'h1234_5678;
      mem[10] = 32'h9ABC_DEF0;
      mem[11] = {OP_NOP, 24'h0000BB};
      mem[12] = {OP_HLT, 24'h0000CC};
      mem[13] = {OP_NOP, 24'h0000DD};
      mem[16] = {OP_NOP, 24'h000010};
      mem[17] = {OP_HLT, 24'h000011};
      mem[18] = {OP_NOP, 24'h000012};
      mem[16'hFFFF] = {OP_NOP, 24'h00FFFF};

      // Reset values
      @(negedge clk);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_exec_valid", 64'(exec_valid), 64'd0);
      check("rst_state", 64'(state), 64'd0);
      check("rst_pc", 64'(pc), 64'd0);
      check("rst_cr", 64'(cr), 64'd0);
      check("rst_retired", 64'(retired), 64'd0);

      // NOP, NOP, HLT from reset
      push(16'd1, mem[0], 64'h0, 1'b1);
      push(16'd2, mem[1], 64'h0, 1'b1);
      push(16'd3, mem[2], 64'h0, 1'b0);
      reset = 1'b1;
      wait_halt();
      check("t1_cr", 64'(cr), 64'h01);
      check("t1_pc", 64'(pc), 64'd3);
      check("t1_retired", 64'(retired), 64'd2);
      check("t1_halt_no_req", {mem_req, mem_addr}, 64'h0);

      // Resume; long LIMM32 latency; CND skip of a long LBSET
      cond_lsb = 1'b0;
      push(16'd4, mem[3], 64'h0, 1'b0);
      push(16'd7, mem[4], {32'hBBBB_0002, 32'hAAAA_0001}, 1'b1);
      push(16'd8, mem[7], 64'h0, 1'b0);
      push(16'd12, mem[11], 64'h0, 1'b0);
      push(16'd13, mem[12], 64'h0, 1'b0);
      pulse_resume();
      check("t6_resume_state", 64'(state), 64'd0);
      check("t6_resume_cr", 64'(cr), 64'h0);
      check("t6_resume_addr", {mem_req, mem_addr}, {47'h0, 1'b1, 16'd3});
      wait_for(2'd0, 16'd4, "t2_fetch0_at_4");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!exec_valid && n < 20);
      check("t2_latency", 64'(n), 64'd3);
      check("t2_pc", 64'(pc), 64'd7);
      wait_for(2'd0, 16'd8, "t3_after_cnd");
      check("t3_skip_set", 64'(cr), 64'h02);
      wait_for(2'd0, 16'd11, "t3_after_lbset");
      check("t3_skip_clear", 64'(cr), 64'h00);
      check("t3_lbset_not_retired", 64'(retired), 64'd5);
      wait_halt();
      check("t3_pc", 64'(pc), 64'd13);
      check("t3_retired", 64'(retired), 64'd6);

      // Wait states in FETCH0, then delayed exec_done with a branch
      ack_en = 1'b0;
      done_delay = 2;
      pc_update_req = 1'b1;
      pc_update_addr = 16'h0010;
      push(16'd14, mem[13], 64'h0, 1'b0);
      pulse_resume();
      for (int i = 0; i < 3; i++) begin
         check("t4_req_held", {mem_req, mem_addr}, {47'h0, 1'b1, 16'd13});
         check("t4_pc_stable", 64'(pc), 64'd13);
         @(negedge clk);
      end
      check("t4_still_fetch0", 64'(state), 64'd0);
      ack_en = 1'b1;
      n = 0;
      while (!exec_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4_latch_4th", 64'(n), 64'd1);
      n = 0;
      while (exec_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("t5_valid_cycles", 64'(n), 64'd3);
      check("t5_branch_addr", {mem_req, mem_addr}, {47'h0, 1'b1, 16'h0010});
      pc_update_req = 1'b0;
      done_delay = 0;
      push(16'd17, mem[16], 64'h0, 1'b0);
      push(16'd18, mem[17], 64'h0, 1'b0);
      wait_halt();
      check("t5_pc", 64'(pc), 64'd18);
      check("t5_retired", 64'(retired), 64'd8);

      // pc wrap through 16'hFFFF
      pc_update_req = 1'b1;
      pc_update_addr = 16'hFFFF;
      push(16'd19, mem[18], 64'h0, 1'b0);
      push(16'd0, mem[16'hFFFF], 64'h0, 1'b0);
      push(16'd1, mem[0], 64'h0, 1'b0);
      push(16'd2, mem[1], 64'h0, 1'b0);
      push(16'd3, mem[2], 64'h0, 1'b0);
      pulse_resume();
      n = 0;
      while (!exec_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (exec_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      pc_update_req = 1'b0;
      check("t5_branch_ffff", {mem_req, mem_addr}, {47'h0, 1'b1, 16'hFFFF});
      wait_for(2'd0, 16'd0, "t5_pc_wrap");
      wait_halt();
      check("t5_wrap_pc", 64'(pc), 64'd3);
      check("t5_wrap_retired", 64'(retired), 64'd12);

      // Reset in the middle of FETCHX
      push(16'd4, mem[3], 64'h0, 1'b0);
      pulse_resume();
      wait_for(2'd1, 16'd5, "t6_in_fetchx");
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_req", 64'(mem_req), 64'd0);
      check("t6_rst_state", 64'(state), 64'd0);
      check("t6_rst_pc", 64'(pc), 64'd0);
      check("t6_rst_ext", instr_ext, 64'h0);
      check("t6_rst_instr0", 64'(instr0), 64'h0);
      check("t6_rst_retired", 64'(retired), 64'd0);
      force_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t6_ack_ignored", {30'h0, state, pc, instr0}, 64'h0);
      force_ack = 1'b0;
      push(16'd1, mem[0], 64'h0, 1'b1);
      push(16'd2, mem[1], 64'h0, 1'b0);
      push(16'd3, mem[2], 64'h0, 1'b0);
      reset = 1'b1;
      wait_halt();
      check("t6_final_retired", 64'(retired), 64'd2);
      check("t6_final_pc", 64'(pc), 64'd3);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Parametrised instruction fetch/sequence controller for the OSECPU core. It fetches variable-length instructions (one opcode word plus up to EXT_WORDS extension words) over a memory interface with wait states. It hands each instruction to the executor via a valid/done handshake, and it maintains the pc and the control register (HLT, SKIP). It adds HLT resume and a retired-instruction counter.

Parameters:
ADDR_W, 16, pc / memory address width
DATA_W, 32, memory and instruction word width
EXT_WORDS, 1, extension words fetched after a long opcode (`OP_LIMM32, `OP_LBSET); legal range 1..3
RESET_PC, 0, pc value loaded on reset
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
mem_addr  out  ADDR_W  fetch address; equals pc while mem_req=1, else 0
mem_req  out  1  fetch request; held high until acknowledged
mem_ack  in  1  request accepted; mem_rdata is valid in the same cycle
mem_rdata  in  DATA_W  fetched word
instr0  out  DATA_W  opcode word of the current instruction; opcode is [DATA_W-1:DATA_W-8]
instr_ext  out  EXT_WORDS*DATA_W  extension words; word k is at [k*DATA_W +: DATA_W]
exec_valid  out  1  instruction ready for the executor (state EXEC)
exec_done  in  1  executor has finished; sampled only in EXEC
cond_lsb  in  1  LSB of the condition register, used by `OP_CND
pc_update_req  in  1  branch request; sampled only when exec_done=1 in EXEC
pc_update_addr  in  ADDR_W  branch target
resume  in  1  clears HLT; honoured only in state HALT
pc  out  ADDR_W  program counter
cr  out  8  {6'b0, SKIP, HLT}; bit 0 is `BIT_CR_HLT, bit 1 is `BIT_CR_SKIP
state  out  2  FETCH0=0, FETCHX=1, EXEC=2, HALT=3
retired  out  CNT_W  count of executed (non-skipped) instructions

Behaviour:
- Reset (reset=0), asynchronous:
  - pc=RESET_PC; state=FETCH0; cr=0; instr0=0; instr_ext=0; retired=0; ext_cnt=0.
  - mem_req and exec_valid are 0 while reset is asserted.
  - Reset mid-transaction aborts the fetch. A mem_ack arriving during reset is ignored.
- mem_req=1 in FETCH0 and FETCHX only, and is held until a posedge with mem_ack=1. mem_ack outside these states is ignored.
- FETCH0, on a posedge with mem_ack=1:
  - instr0<=mem_rdata; pc<=pc+1 (wraps modulo 2^ADDR_W); ext_cnt<=0.
  - Long opcode: go to FETCHX; SKIP is kept.
  - Else if SKIP=1: clear SKIP, stay in FETCH0 (instruction discarded, not counted).
  - Else: go to EXEC.
  - With mem_ack=0: stay, pc unchanged.
- FETCHX, on a posedge with mem_ack=1:
  - instr_ext word[ext_cnt]<=mem_rdata; pc<=pc+1; ext_cnt<=ext_cnt+1.
  - When ext_cnt==EXT_WORDS-1: if SKIP=1, clear SKIP and go to FETCH0; else go to EXEC.
- EXEC: exec_valid=1. instr0 and instr_ext are stable.
  - Stay until exec_done=1. On the exec_done posedge, in priority order:
    - Opcode `OP_HLT: HLT<=1, go to HALT, pc unchanged.
    - Otherwise pc<=pc_update_addr if pc_update_req=1.
    - SKIP<=1 if opcode is `OP_CND and cond_lsb=0, else SKIP<=0.
    - retired<=retired+1 (wraps).
    - Go to FETCH0 (except the `OP_HLT case).
  - A single-cycle executor asserts exec_done in the first EXEC cycle, giving a 1-cycle EXEC.
- HALT:
  - No fetch; pc, instr and retired are frozen; exec_valid=0.
  - resume=1 at a posedge: HLT<=0, go to FETCH0, fetching from the current pc (instruction after the HLT).
  - resume is ignored in all other states.
- Latency with zero wait states:
  - Short instruction: 2 cycles (FETCH0, EXEC).
  - Long instruction: 2+EXT_WORDS cycles.
  - Each wait cycle (mem_ack=0) adds 1 cycle.
- `OP_* and `BIT_CR_* come from def.v. The state encoding is fixed as listed under Ports.

Test Plan:
1. Reset release, RESET_PC=0, mem_ack tied to 1, memory {NOP, NOP, HLT} → exec_valid pulses at pcs 1, 2, 3; state=HALT; cr=8'h01; pc=3; retired=2.
2. EXT_WORDS=2, `OP_LIMM32 at addr 4 with ext words 32'hAAAA_0001 and 32'hBBBB_0002 → instr_ext={32'hBBBB_0002, 32'hAAAA_0001} in EXEC; pc=7; the EXEC cycle begins 3 posedges after FETCH0 starts.
3. `OP_CND with cond_lsb=0 followed by a long `OP_LBSET and then a NOP → LBSET and all its ext words are fetched but not executed; SKIP is cleared after them; the NOP executes; retired increments by 2 (CND, NOP).
4. mem_ack held low for 3 cycles in FETCH0 → mem_req stays high, mem_addr=pc is stable, pc does not advance; the word is latched on the 4th cycle.
5. exec_done delayed 2 cycles with pc_update_req=1 and pc_update_addr=16'h0010 → exec_valid is high for 3 cycles; the next fetch has mem_addr=16'h0010. pc=16'hFFFF with a NOP → pc wraps to 0.
6. HALT then resume pulse → fetch restarts at pc, cr=0. Reset asserted mid-FETCHX with mem_ack=1 → mem_req drops immediately; after release, pc=RESET_PC and instr_ext=0.
